// File: rtl/uart_tx_fifo.sv
// Debug UART transmit path: byte FIFO feeding an 8N1 serializer.
// Writes into a full FIFO are dropped and latch a sticky overflow flag.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               busy,
    output logic               tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [LEVEL_W-1:0] r_wptr;
    logic [LEVEL_W-1:0] r_rptr;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_wptr_nxt;
    logic [LEVEL_W-1:0] w_rptr_nxt;
    logic [LEVEL_W-1:0] w_level_nxt;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic               r_busy;
    logic               r_tx;
    logic [7:0]         r_shift;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit;

    logic               w_push;
    logic               w_pop;
    logic               w_baud_last;
    logic               w_tx_nxt;
    logic [7:0]         w_shift_nxt;
    logic [15:0]        w_baud_nxt;
    logic [2:0]         w_bit_nxt;

    assign w_push      = wr_en & ~r_full;
    assign w_baud_last = (r_baud == BAUD_LAST);

    // Pointer MSB separates full from empty; level is their difference.
    assign w_wptr_nxt  = r_wptr + LEVEL_W'(w_push);
    assign w_rptr_nxt  = r_rptr + LEVEL_W'(w_pop);
    assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == DEPTH_L);
            r_empty <= (w_level_nxt == '0);
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_busy  <= (w_state_nxt != IDLE) | (w_level_nxt != '0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr[AW-1:0]];
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign tx       = r_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a CLK_DIV=4/depth-16 instance and
// a CLK_DIV=2/depth-4 instance, with a frame receiver per instance.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en_a = 1'b0;
    logic [7:0] wr_data_a = 8'h00;
    logic       full_a, empty_a, overflow_a, busy_a, tx_a;
    logic [4:0] level_a;
    logic       wr_en_b = 1'b0;
    logic [7:0] wr_data_b = 8'h00;
    logic       full_b, empty_b, overflow_b, busy_b, tx_b;
    logic [2:0] level_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_a [$];
    logic [7:0] rx_b [$];
    int st_a [$];
    int st_b [$];

    uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .full(full_a), .empty(empty_a), .level(level_a),
        .overflow(overflow_a), .busy(busy_a), .tx(tx_a)
    );

    uart_tx_fifo #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .full(full_b), .empty(empty_b), .level(level_b),
        .overflow(overflow_b), .busy(busy_b), .tx(tx_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples each bit at its middle, starting from the first low negedge.
    task automatic rx_frame(input int which, output logic [7:0] b);
        int div;
        div = (which == 0) ? 4 : 2;
        b = '0;
        repeat (div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = (which == 0) ? tx_a : tx_b;
        end
        repeat (div) @(negedge clk);
    endtask

    always begin : rx_a_proc
        logic [7:0] b;
        @(negedge clk);
        if (tx_a === 1'b0) begin
            st_a.push_back(cyc);
            rx_frame(0, b);
            rx_a.push_back(b);
        end
    end

    always begin : rx_b_proc
        logic [7:0] b;
        @(negedge clk);
        if (tx_b === 1'b0) begin
            st_b.push_back(cyc);
            rx_frame(1, b);
            rx_b.push_back(b);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rx_a.delete();
        rx_b.delete();
        st_a.delete();
        st_b.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tx_a !== 1'b1) begin
            errors++; $display("FAIL reset_tx: got %b want 1", tx_a);
        end
        checks++;
        if (full_a !== 1'b0) begin
            errors++; $display("FAIL reset_full: got %b want 0", full_a);
        end
        checks++;
        if (empty_a !== 1'b1) begin
            errors++; $display("FAIL reset_empty: got %b want 1", empty_a);
        end
        checks++;
        if (level_a !== 5'd0) begin
            errors++; $display("FAIL reset_level: got %0d want 0", level_a);
        end
        checks++;
        if (overflow_a !== 1'b0) begin
            errors++; $display("FAIL reset_ovf: got %b want 0", overflow_a);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy_a);
        end
        checks++;
        if (tx_b !== 1'b1 || empty_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_b: got tx=%b empty=%b want 1 1", tx_b, empty_b);
        end
    endtask

    task automatic test_single();
        logic [7:0] d = 8'h55;
        logic exp;
        do_reset();
        wr_en_a = 1'b1;
        wr_data_a = d;
        tick();
        wr_en_a = 1'b0;
        checks++;
        if (level_a !== 5'd1 || empty_a !== 1'b0) begin
            errors++;
            $display("FAIL single_e0: got level=%0d empty=%b want 1 0",
                     level_a, empty_a);
        end
        for (int c = 1; c <= 42; c++) begin
            tick();
            if (c <= 4) exp = 1'b0;
            else if (c <= 36) exp = d[(c - 5) / 4];
            else exp = 1'b1;
            if (c <= 40) begin
                checks++;
                if (tx_a !== exp) begin
                    errors++;
                    $display("FAIL single_tx c%0d: got %b want %b", c, tx_a, exp);
                end
                checks++;
                if (busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy c%0d: got %b want 1", c, busy_a);
                end
            end
            if (c == 1) begin
                checks++;
                if (level_a !== 5'd0) begin
                    errors++;
                    $display("FAIL single_level: got %0d want 0", level_a);
                end
            end
            if (c == 42) begin
                checks++;
                if (busy_a !== 1'b0) begin
                    errors++;
                    $display("FAIL single_idle: got busy=%b want 0", busy_a);
                end
            end
        end
        checks++;
        if (rx_a.size() != 1 || rx_a[0] !== d) begin
            errors++;
            $display("FAIL single_rx: got %0d bytes first=%h want 1 byte 55",
                     rx_a.size(), (rx_a.size() > 0) ? rx_a[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int maxlvl = 0;
        do_reset();
        wr_en_a = 1'b1;
        wr_data_a = 8'hA3;
        tick();
        t0 = cyc;
        if (level_a > maxlvl) maxlvl = level_a;
        wr_data_a = 8'h0F;
        tick();
        wr_en_a = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (level_a > maxlvl) maxlvl = level_a;
            tick();
        end
        checks++;
        if (maxlvl != 1) begin
            errors++; $display("FAIL b2b_peak: got %0d want 1", maxlvl);
        end
        checks++;
        if (rx_a.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d want 2", rx_a.size());
        end else begin
            checks++;
            if (rx_a[0] !== 8'hA3 || rx_a[1] !== 8'h0F) begin
                errors++;
                $display("FAIL b2b_data: got %h %h want a3 0f", rx_a[0], rx_a[1]);
            end
        end
        checks++;
        if (st_a.size() != 2) begin
            errors++; $display("FAIL b2b_starts: got %0d want 2", st_a.size());
        end else begin
            checks++;
            if (st_a[1] - st_a[0] != 41) begin
                errors++;
                $display("FAIL b2b_pitch: got %0d want 41", st_a[1] - st_a[0]);
            end
            checks++;
            if (st_a[0] != t0 + 1) begin
                errors++;
                $display("FAIL b2b_latency: got %0d want %0d", st_a[0], t0 + 1);
            end
        end
    endtask

    task automatic test_overflow();
        int t0 = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wr_en_a = 1'b1;
            wr_data_a = 8'(i);
            tick();
            if (i == 0) begin
                t0 = cyc;
                checks++;
                if (overflow_a !== 1'b0) begin
                    errors++; $display("FAIL ovf_early: got %b want 0", overflow_a);
                end
            end
            if (i == 15) begin
                checks++;
                if (full_a !== 1'b0) begin
                    errors++; $display("FAIL ovf_full15: got %b want 0", full_a);
                end
            end
            if (i == 16) begin
                checks++;
                if (full_a !== 1'b1 || level_a !== 5'd16 || overflow_a !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full16: got full=%b level=%0d ovf=%b want 1 16 0",
                             full_a, level_a, overflow_a);
                end
            end
            if (i == 17) begin
                checks++;
                if (overflow_a !== 1'b1 || level_a !== 5'd16) begin
                    errors++;
                    $display("FAIL ovf_drop: got ovf=%b level=%0d want 1 16",
                             overflow_a, level_a);
                end
            end
        end
        wr_en_a = 1'b0;
        for (int k = 0; k < 800 && rx_a.size() < 17; k++) tick();
        repeat (60) tick();
        checks++;
        if (rx_a.size() != 17) begin
            errors++; $display("FAIL ovf_count: got %0d want 17", rx_a.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                checks++;
                if (rx_a[k] !== 8'(k)) begin
                    errors++;
                    $display("FAIL ovf_byte%0d: got %h want %h", k, rx_a[k], 8'(k));
                end
            end
        end
        checks++;
        if (st_a.size() == 0 || st_a[0] != t0 + 1) begin
            errors++; $display("FAIL ovf_pop0: got first start wrong want %0d", t0 + 1);
        end
        checks++;
        if (overflow_a !== 1'b1 || empty_a !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b empty=%b want 1 1",
                     overflow_a, empty_a);
        end
    endtask

    task automatic test_reset_midframe();
        logic idle_ok = 1'b1;
        rx_a.delete();
        st_a.delete();
        wr_en_a = 1'b1;
        wr_data_a = 8'hF7;
        tick();
        wr_data_a = 8'h11;
        tick();
        wr_data_a = 8'h22;
        tick();
        wr_en_a = 1'b0;
        repeat (15) tick();
        checks++;
        if (tx_a !== 1'b0 || level_a !== 5'd2 || overflow_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got tx=%b level=%0d ovf=%b want 0 2 1",
                     tx_a, level_a, overflow_a);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (tx_a !== 1'b1 || empty_a !== 1'b1 || level_a !== 5'd0) begin
            errors++;
            $display("FAIL mid_rst: got tx=%b empty=%b level=%0d want 1 1 0",
                     tx_a, empty_a, level_a);
        end
        checks++;
        if (busy_a !== 1'b0 || overflow_a !== 1'b0 || full_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_flags: got busy=%b ovf=%b full=%b want 0 0 0",
                     busy_a, overflow_a, full_a);
        end
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx_a !== 1'b1) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok || st_a.size() != 1) begin
            errors++;
            $display("FAIL mid_quiet: got idle=%b starts=%0d want 1 1",
                     idle_ok, st_a.size());
        end
    endtask

    task automatic test_write_pop();
        do_reset();
        wr_en_a = 1'b1;
        wr_data_a = 8'h3C;
        tick();
        wr_en_a = 1'b0;
        tick();
        wr_en_a = 1'b1;
        wr_data_a = 8'hC3;
        tick();
        wr_en_a = 1'b0;
        repeat (39) tick();
        checks++;
        if (level_a !== 5'd1 || tx_a !== 1'b1) begin
            errors++;
            $display("FAIL wp_pre: got level=%0d tx=%b want 1 1", level_a, tx_a);
        end
        wr_en_a = 1'b1;
        wr_data_a = 8'h5A;
        tick();
        wr_en_a = 1'b0;
        checks++;
        if (level_a !== 5'd1 || overflow_a !== 1'b0 || tx_a !== 1'b0) begin
            errors++;
            $display("FAIL wp_edge: got level=%0d ovf=%b tx=%b want 1 0 0",
                     level_a, overflow_a, tx_a);
        end
        repeat (100) tick();
        checks++;
        if (rx_a.size() != 3) begin
            errors++; $display("FAIL wp_count: got %0d want 3", rx_a.size());
        end else begin
            checks++;
            if (rx_a[0] !== 8'h3C || rx_a[1] !== 8'hC3 || rx_a[2] !== 8'h5A) begin
                errors++;
                $display("FAIL wp_data: got %h %h %h want 3c c3 5a",
                         rx_a[0], rx_a[1], rx_a[2]);
            end
            checks++;
            if (st_a[2] - st_a[1] != 41) begin
                errors++;
                $display("FAIL wp_pitch: got %0d want 41", st_a[2] - st_a[1]);
            end
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        logic seen_full = 1'b0;
        logic [7:0] exp [40];
        do_reset();
        for (int i = 0; i < 40; i++) exp[i] = 8'((i * 37 + 11) % 256);
        for (int k = 0; k < 1500 && rx_b.size() < 40; k++) begin
            if (sent < 40 && level_b < 3'd3) begin
                wr_en_b = 1'b1;
                wr_data_b = exp[sent];
                sent++;
            end else begin
                wr_en_b = 1'b0;
            end
            tick();
            if (full_b === 1'b1) seen_full = 1'b1;
        end
        wr_en_b = 1'b0;
        repeat (30) tick();
        checks++;
        if (rx_b.size() != 40) begin
            errors++; $display("FAIL wrap_count: got %0d want 40", rx_b.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rx_b[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL wrap_byte%0d: got %h want %h", i, rx_b[i], exp[i]);
                end
            end
        end
        checks++;
        if (seen_full !== 1'b0) begin
            errors++; $display("FAIL wrap_full: got %b want 0", seen_full);
        end
        checks++;
        if (empty_b !== 1'b1 || level_b !== 3'd0 || overflow_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: got empty=%b level=%0d ovf=%b want 1 0 0",
                     empty_b, level_b, overflow_b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_write_pop();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Debug UART transmit path; sits directly downstream of the memory map's UART decode at 0x8000_0000.
- The memory map issues a one-cycle byte strobe for each data-bus write to that address.
- This block buffers those bytes in a FIFO and serializes them as 8N1 on a single tx pin.
- It also reports busy/level/overflow status so software or the bench can poll or detect drops.

Parameters:
- CLK_DIV, 434: clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16: byte entries; must be a power of two, minimum 2.
- LEVEL_W, $clog2(FIFO_DEPTH)+1: width of the level output.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  byte strobe from the memory map (UART write, wren=1, addr 0x8000_0000).
- wr_data  in  8  byte to send (data_data[7:0]).
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  LEVEL_W  FIFO occupancy; excludes the byte in the serializer.
- overflow  out  1  sticky; set when a write is dropped.
- busy  out  1  serializer not IDLE, or FIFO not empty.
- tx  out  1  serial line, idle high, registered.

Behaviour:
- One clock; reset is synchronous and active-high, on clk/reset.
- Reset values: tx=1, full=0, empty=1, level=0, overflow=0, busy=0. Pointers, bit counter, baud counter and shift register are all cleared; state=IDLE.
- Reset mid-frame: tx goes to 1 at the reset edge, the frame is abandoned, and the FIFO contents are discarded.

FIFO:
- Circular buffer; read/write pointers are LEVEL_W wide, so the MSB distinguishes full from empty. Pointers wrap modulo 2*FIFO_DEPTH.
- A write is accepted when wr_en=1 and full=0 (full as registered before the edge). Level increments at that edge.
- A write while full is dropped even if a pop occurs the same cycle; overflow is set. Overflow clears only on reset.
- A simultaneous accepted write and pop leaves level unchanged.
- full, empty and level are registered and reflect the state after the edge.

Serializer FSM: IDLE, START, DATA, STOP.
- IDLE: if empty=0, pop the head byte into the shift register, tx<=0, baud counter<=0, go to START. Otherwise tx stays 1.
- START: hold tx=0 for CLK_DIV cycles. At the last cycle, tx<=shift[0], bit index<=0, go to DATA.
- DATA: each bit is held CLK_DIV cycles, LSB first. At the end of bit i<7, shift right and drive the next bit. At the end of bit 7, tx<=1 and go to STOP.
- STOP: hold tx=1 for CLK_DIV cycles, then go to IDLE.
- Back-to-back frames: at STOP completion the block goes to IDLE. IDLE pops on the next edge if the FIFO is non-empty, giving exactly 1 extra idle-high cycle between frames.
- Frame length is therefore 10*CLK_DIV cycles; frame pitch with a non-empty FIFO is 10*CLK_DIV+1 cycles.
- Latency: a byte written at edge k into an empty FIFO with an IDLE serializer gives empty=0 after edge k. It is popped at edge k+1, and the tx start bit begins at edge k+1.
- The baud counter is 16 bits and counts 0..CLK_DIV-1. Wrap to 0 marks the end of a bit.
- busy = (state != IDLE) | ~empty, registered.

Test Plan:
- Single byte, CLK_DIV=4: wr_en with 0x55 at edge 0 -> tx low from edge 1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop high for 4 cycles. busy=1 for cycles 1..40 and 0 at 42. level returns to 0 after edge 1.
- Back-to-back, CLK_DIV=4: write 0xA3 and 0x0F on consecutive cycles -> two frames decode correctly. Second start bit begins exactly 41 cycles after the first; level peaks at 1.
- Overflow, FIFO_DEPTH=16, CLK_DIV=4: 18 writes on consecutive cycles with values 0..17 -> byte 0 popped at edge 1; full=1 after edge 16; byte 17 dropped; overflow=1. tx then emits 0..16 in order, and overflow stays 1.
- Write+pop same cycle: with level=1 and serializer at STOP completion, write during the IDLE pop edge -> level stays 1 and there is no overflow.
- Pointer wrap, FIFO_DEPTH=4, CLK_DIV=2: stream 40 bytes paced to keep level ≤3 -> all 40 are received in order; full never asserts; empty=1 at end.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> after the reset edge, tx=1, empty=1, level=0, busy=0, overflow=0. No further start bit occurs until a new write.
